// File: rtl/ext_code_seq_if.sv
// Host-side strobe/data bundle and code outputs of the external-code sequencer.
// The host (master) drives the strobes and trigger; the sequencer (slave) drives code/index/status.
interface ext_code_seq_if #(
  parameter int CODE_W  = 32,
  parameter int INDEX_W = 3
);
  logic              iSET_CODE_FLAG;
  logic [CODE_W-1:0] iSET_CODE;
  logic              iSET_INDEX_FLAG;
  logic [INDEX_W-1:0] iSET_INDEX;
  logic              iTrigger;
  logic [CODE_W-1:0] oCode;
  logic [INDEX_W-1:0] oIndex;
  logic              oExhausted;
  logic              oStep;

  modport master (
    output iSET_CODE_FLAG, iSET_CODE, iSET_INDEX_FLAG, iSET_INDEX, iTrigger,
    input  oCode, oIndex, oExhausted, oStep
  );

  modport slave (
    input  iSET_CODE_FLAG, iSET_CODE, iSET_INDEX_FLAG, iSET_INDEX, iTrigger,
    output oCode, oIndex, oExhausted, oStep
  );
endinterface

// File: rtl/ext_code_seq.sv
// External-code sequencer: DEPTH stored codes presented on each trigger pulse, index stepping down.
// Optional macro EXT_CODE_WR_AUTOINC_EN: each code write advances the index by +1 for burst loading.
module ext_code_seq #(
  parameter int CODE_W  = 32,
  parameter int INDEX_W = 3,
  parameter int DEPTH   = 8,
  parameter int WRAP    = 1
) (
  input logic iClk,
  input logic iRst,
  ext_code_seq_if.slave bus
);

  localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(DEPTH - 1);
  localparam logic [INDEX_W:0]   DEPTH_EXT = (INDEX_W + 1)'(DEPTH);

  logic [CODE_W-1:0]  storage [DEPTH];
  logic [INDEX_W-1:0] index;
  logic [CODE_W-1:0]  codeReg;
  logic               exhaustedReg;
  logic               stepReg;
  logic               setCodePrev;
  logic               setIndexPrev;
  logic               triggerPrev;

  logic               setCodeRise;
  logic               setIndexRise;
  logic               triggerFall;
  logic [INDEX_W-1:0] presetIndex;
  logic [INDEX_W-1:0] incIndex;

  assign setCodeRise  = bus.iSET_CODE_FLAG & ~setCodePrev;
  assign setIndexRise = bus.iSET_INDEX_FLAG & ~setIndexPrev;
  assign triggerFall  = ~bus.iTrigger & triggerPrev;

  // Out-of-range presets clamp to the last stored word.
  assign presetIndex = ({1'b0, bus.iSET_INDEX} >= DEPTH_EXT) ? LAST_IDX : bus.iSET_INDEX;
  assign incIndex    = (index == LAST_IDX) ? '0 : index + 1'b1;

  // Priority on index update: preset, then write auto-increment (if built in), then trigger step.
  // The code write and the oCode read both use the index as it was before this edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
      index        <= LAST_IDX;
      codeReg      <= '0;
      exhaustedReg <= 1'b0;
      stepReg      <= 1'b0;
      setCodePrev  <= 1'b0;
      setIndexPrev <= 1'b0;
      triggerPrev  <= 1'b0;
    end else begin
      setCodePrev  <= bus.iSET_CODE_FLAG;
      setIndexPrev <= bus.iSET_INDEX_FLAG;
      triggerPrev  <= bus.iTrigger;
      stepReg      <= 1'b0;
      codeReg      <= bus.iTrigger ? storage[index] : '0;
      if (setCodeRise) begin
        storage[index] <= bus.iSET_CODE;
      end
      if (setIndexRise) begin
        index        <= presetIndex;
        exhaustedReg <= 1'b0;
      end
`ifdef EXT_CODE_WR_AUTOINC_EN
      else if (setCodeRise) begin
        index <= incIndex;
      end
`endif
      else if (triggerFall) begin
        if (index != '0) begin
          index   <= index - 1'b1;
          stepReg <= 1'b1;
        end else if (WRAP != 0) begin
          index   <= LAST_IDX;
          stepReg <= 1'b1;
        end else begin
          exhaustedReg <= 1'b1;
        end
      end
    end
  end

`ifndef EXT_CODE_WR_AUTOINC_EN
  logic unusedIncIndex;
  assign unusedIncIndex = ^incIndex;
`endif

  assign bus.oCode      = codeReg;
  assign bus.oIndex     = index;
  assign bus.oExhausted = exhaustedReg;
  assign bus.oStep      = stepReg;

endmodule
